main_ram_arbiter: RTL and testbench
===================================

# main_ram_arbiter

Sequencer and arbiter for the single SDRAM main-memory port in the SNES top level. It shares the port between three requesters:
- the game loader (ROM image writes before `load_done`);
- the core's ROM read port;
- the core's BSRAM (save RAM) byte port.

It maps each requester into the 25-bit SDRAM address space, issues one command at a time and returns the read data with a completion pulse. An optional fourth port carries ESP32 SPI host access.

## Interface
- `ROM_AW`, 24, ROM byte-address width; mapped to `{1'b0, rom_addr}`
- `BSRAM_AW`, 20, BSRAM address width; mapped to `{5'b10000, bsram_addr}`
- `STARVE_MAX`, 8, consecutive core grants before a waiting SPI request is forced in
- `clk`  in  1  system clock (clk_sys domain)
- `reset_n`  in  1  asynchronous active-low reset
- `load_done`  in  1  loader finished; 0 = loader-only mode
- `load_req`  in  1  loader write request, held until `load_ack`
- `load_addr`  in  25  loader word address
- `load_data`  in  16  loader write data
- `load_ack`  out  1  one-cycle pulse: loader write completed
- `rom_req`  in  1  ROM read request, held until `rom_valid`
- `rom_addr`  in  ROM_AW  ROM address
- `rom_word`  in  1  1 = 16-bit read, 0 = byte read
- `rom_q`  out  16  ROM read data, stable from `rom_valid` until the next ROM grant
- `rom_valid`  out  1  one-cycle pulse: `rom_q` valid
- `bsram_req`  in  1  BSRAM request, held until `bsram_valid`
- `bsram_we`  in  1  1 = write, 0 = read
- `bsram_addr`  in  BSRAM_AW  BSRAM address
- `bsram_d`  in  8  BSRAM write byte
- `bsram_q`  out  8  BSRAM read byte, stable until the next BSRAM grant
- `bsram_valid`  out  1  one-cycle pulse: BSRAM access completed
- `spi_req`, `spi_we`, `spi_addr[24:0]`, `spi_d[7:0]`  in  SPI host byte access (`ESP32_PORT_EN` only)
- `spi_q`  out  8  SPI read byte; `spi_ack`  out  1  completion pulse (`ESP32_PORT_EN` only)
- `mem_addr`  out  25  SDRAM address
- `mem_rd`, `mem_wr`  out  1  one-cycle command strobes
- `mem_word`  out  1  16-bit access
- `mem_din`  out  16  write data
- `mem_dout`  in  16  read data, valid when `mem_busy` falls
- `mem_busy`  in  1  SDRAM controller busy

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Sample requests; grant one; register address, data, word flag and a 2-bit owner ID into a command latch; go to ISSUE.
- ISSUE:
  - Assert `mem_rd` or `mem_wr` for exactly one cycle from the latch; go to WAIT_BUSY.
- WAIT_BUSY:
  - `mem_busy`=1 → WAIT_DONE.
  - If `mem_busy` is not seen within 2 cycles, the command counts as complete and the FSM goes to completion handling.
- WAIT_DONE:
  - On `mem_busy`=0: capture `mem_dout` for reads, pulse the owner's ack/valid, return to IDLE.
- Grant rules when `load_done`=0: only the loader is eligible; all other requests wait.
- Grant rules when `load_done`=1: loader requests are ignored; priority is BSRAM > ROM > SPI.
- Starvation counter increments on each core grant while `spi_req`=1. At `STARVE_MAX`, the next IDLE grant goes to SPI and the counter clears. It also clears on any SPI grant.
- Loader accesses: `mem_word`=1, `mem_din`=`load_data`.
- BSRAM accesses:
  - `mem_word`=0, `mem_din`=`{bsram_d,bsram_d}`.
  - Reads return `mem_dout[7:0]`.
- SPI accesses: same byte rules as BSRAM.
- ROM accesses: `mem_word`=`rom_word`, `mem_wr` is never issued.
- A request dropped before grant is simply not served. A request dropped after grant still completes, and its pulse is still emitted.
- `load_done` falling mid-transaction: the current command completes normally, then loader-only mode applies.

## Timing
- Reset values: FSM=IDLE; `mem_rd`=`mem_wr`=`mem_word`=0; `mem_addr`=0; `mem_din`=0; all ack/valid=0; `rom_q`=`bsram_q`=`spi_q`=0; starvation counter 0.
- Asynchronous reset assertion mid-transaction aborts it immediately. No pulse is emitted.
- Minimum latency, from request seen in IDLE to ack/valid, with `mem_busy` rising one cycle after the strobe and lasting N cycles: 3+N cycles.
- Ack/valid is registered and appears the cycle after `mem_busy` falls. The FSM is in IDLE that same cycle.
- A requester deasserts `req` in the cycle it sees its pulse. A `req` still high on the cycle after the pulse is treated as a new request.
- Back-to-back throughput: one command per 3+N cycles. IDLE always lasts exactly one cycle.
- Simultaneous BSRAM and ROM requests in IDLE: BSRAM is granted, ROM is served next.

## Configuration
- `ESP32_PORT_EN` defined:
  - SPI ports exist and arbitration includes SPI with the starvation guard.
- `ESP32_PORT_EN` undefined:
  - SPI ports are absent and the starvation counter is removed.
  - Arbitration covers loader/BSRAM/ROM only. Behaviour is otherwise identical.

## Test plan
- Loader mode: `load_done`=0, `load_req` with addr `0x000123`, data `0xBEEF` → one `mem_wr`, `mem_addr`=`0x000123`, `mem_word`=1, `load_ack` one cycle after `mem_busy` falls. A concurrent `rom_req` gets no grant.
- ROM read: `rom_addr`=`0x012345`, `rom_word`=1, model returns `0xA55A` → `mem_addr`=`0x0012345`, `rom_q`=`0xA55A`, `rom_valid` pulse.
- BSRAM byte write then read at `0x00010`, data `0x7E` → `mem_addr`=`0x1000010`, `mem_din`=`0x7E7E`, `mem_word`=0, `bsram_q`=`0x7E`.
- Contention: `rom_req` and `bsram_req` raised in the same cycle → BSRAM completes first, ROM second. Exactly two strobes are issued.
- `ESP32_PORT_EN`: `rom_req` held continuously, `spi_req` held → SPI is granted on the 9th grant. `spi_ack` is pulsed.
- Reset and no-busy cases:
  - Assert `reset_n`=0 during WAIT_DONE → all outputs zero immediately, no pulse after release.
  - Model never raises `mem_busy` → completion pulse 2 cycles after the strobe.

Source files
------------

// File: rtl/main_ram_arbiter.sv
// main_ram_arbiter
//   Sequencer/arbiter for the single SDRAM main-memory port. It shares the
//   port between the game loader, the core ROM read port, the core BSRAM byte
//   port and, optionally, an ESP32 SPI host byte port. It issues one command
//   at a time and returns read data with a one-cycle completion pulse.
//
// Build option:
//   ESP32_PORT_EN  defined   -> SPI host port and starvation guard present
//                  undefined -> loader/BSRAM/ROM arbitration only
//
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   load_done                          0 = loader-only mode
//   load_req/addr/data -> load_ack     loader word writes
//   rom_req/addr/word  -> rom_q/valid  ROM reads (byte or word)
//   bsram_req/we/addr/d -> bsram_q/valid  BSRAM byte accesses
//   spi_req/we/addr/d  -> spi_q/ack    SPI host byte accesses (optional)
//   mem_addr/rd/wr/word/din            SDRAM command side
//   mem_dout, mem_busy                 SDRAM response side
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | sample requests, grant one, load the command latch
// S_ISSUE     | drive mem_rd or mem_wr for one cycle
// S_WAIT_BUSY | wait for the controller to raise mem_busy
// S_WAIT_DONE | wait for mem_busy to fall, capture data, pulse owner
module main_ram_arbiter #(
  parameter int ROM_AW     = 24,
  parameter int BSRAM_AW   = 20,
  parameter int STARVE_MAX = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load_done,
  input  logic                load_req,
  input  logic [24:0]         load_addr,
  input  logic [15:0]         load_data,
  output logic                load_ack,
  input  logic                rom_req,
  input  logic [ROM_AW-1:0]   rom_addr,
  input  logic                rom_word,
  output logic [15:0]         rom_q,
  output logic                rom_valid,
  input  logic                bsram_req,
  input  logic                bsram_we,
  input  logic [BSRAM_AW-1:0] bsram_addr,
  input  logic [7:0]          bsram_d,
  output logic [7:0]          bsram_q,
  output logic                bsram_valid,
`ifdef ESP32_PORT_EN
  input  logic                spi_req,
  input  logic                spi_we,
  input  logic [24:0]         spi_addr,
  input  logic [7:0]          spi_d,
  output logic [7:0]          spi_q,
  output logic                spi_ack,
`endif
  output logic [24:0]         mem_addr,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                mem_word,
  output logic [15:0]         mem_din,
  input  logic [15:0]         mem_dout,
  input  logic                mem_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

  localparam logic [1:0] OWN_LOAD  = 2'd0;
  localparam logic [1:0] OWN_ROM   = 2'd1;
  localparam logic [1:0] OWN_BSRAM = 2'd2;
  localparam logic [1:0] OWN_SPI   = 2'd3;

  // BSRAM lives in the upper half of the SDRAM address space.
  localparam logic [24:0] BSRAM_BASE = 25'h1000000;

  state_t      state_q, state_d;
  logic [24:0] cmd_addr_q, cmd_addr_d;
  logic [15:0] cmd_din_q, cmd_din_d;
  logic        cmd_word_q, cmd_word_d;
  logic        cmd_we_q, cmd_we_d;
  logic [1:0]  cmd_own_q, cmd_own_d;
  logic        load_ack_q, load_ack_d;
  logic        rom_valid_q, rom_valid_d;
  logic        bsram_valid_q, bsram_valid_d;
  logic [15:0] rom_data_q, rom_data_d;
  logic [7:0]  bsram_data_q, bsram_data_d;
  logic        gnt_load, gnt_rom, gnt_bsram;
  logic        complete;

`ifdef ESP32_PORT_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q, starve_d;
  logic          spi_ack_q, spi_ack_d;
  logic [7:0]    spi_data_q, spi_data_d;
  logic          gnt_spi;
`else
  logic unused_cfg;
  assign unused_cfg = (STARVE_MAX > 0);
`endif

  // Grant selection; only meaningful while in S_IDLE.
  always_comb begin
    gnt_load  = 1'b0;
    gnt_rom   = 1'b0;
    gnt_bsram = 1'b0;
`ifdef ESP32_PORT_EN
    gnt_spi   = 1'b0;
`endif
    if (!load_done) gnt_load = load_req;
`ifdef ESP32_PORT_EN
    else if (spi_req && (starve_q >= SW'(STARVE_MAX))) gnt_spi = 1'b1;
`endif
    else if (bsram_req) gnt_bsram = 1'b1;
    else if (rom_req)   gnt_rom   = 1'b1;
`ifdef ESP32_PORT_EN
    else if (spi_req)   gnt_spi   = 1'b1;
`endif
  end

  always_comb begin
    state_d       = state_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_din_d     = cmd_din_q;
    cmd_word_d    = cmd_word_q;
    cmd_we_d      = cmd_we_q;
    cmd_own_d     = cmd_own_q;
    load_ack_d    = 1'b0;
    rom_valid_d   = 1'b0;
    bsram_valid_d = 1'b0;
    rom_data_d    = rom_data_q;
    bsram_data_d  = bsram_data_q;
    complete      = 1'b0;
`ifdef ESP32_PORT_EN
    starve_d      = starve_q;
    spi_ack_d     = 1'b0;
    spi_data_d    = spi_data_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (gnt_load) begin
          cmd_addr_d = load_addr;
          cmd_din_d  = load_data;
          cmd_word_d = 1'b1;
          cmd_we_d   = 1'b1;
          cmd_own_d  = OWN_LOAD;
          state_d    = S_ISSUE;
        end else if (gnt_bsram) begin
          cmd_addr_d = 25'(bsram_addr) | BSRAM_BASE;
          cmd_din_d  = {bsram_d, bsram_d};
          cmd_word_d = 1'b0;
          cmd_we_d   = bsram_we;
          cmd_own_d  = OWN_BSRAM;
          state_d    = S_ISSUE;
        end else if (gnt_rom) begin
          cmd_addr_d = 25'(rom_addr);
          cmd_din_d  = 16'h0000;
          cmd_word_d = rom_word;
          cmd_we_d   = 1'b0;
          cmd_own_d  = OWN_ROM;
          state_d    = S_ISSUE;
        end
`ifdef ESP32_PORT_EN
        else if (gnt_spi) begin
          cmd_addr_d = spi_addr;
          cmd_din_d  = {spi_d, spi_d};
          cmd_word_d = 1'b0;
          cmd_we_d   = spi_we;
          cmd_own_d  = OWN_SPI;
          state_d    = S_ISSUE;
        end
        if (gnt_spi) begin
          starve_d = '0;
        end else if ((gnt_bsram || gnt_rom) && spi_req &&
                     (starve_q < SW'(STARVE_MAX))) begin
          starve_d = starve_q + SW'(1);
        end
`endif
      end
      S_ISSUE: state_d = S_WAIT_BUSY;
      // The strobe cycle plus this one form the window for mem_busy to rise;
      // a controller that never goes busy is treated as already finished.
      S_WAIT_BUSY: begin
        if (mem_busy) state_d = S_WAIT_DONE;
        else          complete = 1'b1;
      end
      S_WAIT_DONE: begin
        if (!mem_busy) complete = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      state_d = S_IDLE;
      case (cmd_own_q)
        OWN_LOAD: load_ack_d = 1'b1;
        OWN_ROM: begin
          rom_valid_d = 1'b1;
          rom_data_d  = mem_dout;
        end
        OWN_BSRAM: begin
          bsram_valid_d = 1'b1;
          if (!cmd_we_q) bsram_data_d = mem_dout[7:0];
        end
        default: begin
`ifdef ESP32_PORT_EN
          spi_ack_d = 1'b1;
          if (!cmd_we_q) spi_data_d = mem_dout[7:0];
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cmd_addr_q    <= '0;
      cmd_din_q     <= '0;
      cmd_word_q    <= 1'b0;
      cmd_we_q      <= 1'b0;
      cmd_own_q     <= OWN_LOAD;
      load_ack_q    <= 1'b0;
      rom_valid_q   <= 1'b0;
      bsram_valid_q <= 1'b0;
      rom_data_q    <= '0;
      bsram_data_q  <= '0;
`ifdef ESP32_PORT_EN
      starve_q      <= '0;
      spi_ack_q     <= 1'b0;
      spi_data_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_din_q     <= cmd_din_d;
      cmd_word_q    <= cmd_word_d;
      cmd_we_q      <= cmd_we_d;
      cmd_own_q     <= cmd_own_d;
      load_ack_q    <= load_ack_d;
      rom_valid_q   <= rom_valid_d;
      bsram_valid_q <= bsram_valid_d;
      rom_data_q    <= rom_data_d;
      bsram_data_q  <= bsram_data_d;
`ifdef ESP32_PORT_EN
      starve_q      <= starve_d;
      spi_ack_q     <= spi_ack_d;
      spi_data_q    <= spi_data_d;
`endif
    end
  end

  assign mem_rd      = (state_q == S_ISSUE) && !cmd_we_q;
  assign mem_wr      = (state_q == S_ISSUE) &&  cmd_we_q;
  assign mem_addr    = cmd_addr_q;
  assign mem_word    = cmd_word_q;
  assign mem_din     = cmd_din_q;
  assign load_ack    = load_ack_q;
  assign rom_valid   = rom_valid_q;
  assign rom_q       = rom_data_q;
  assign bsram_valid = bsram_valid_q;
  assign bsram_q     = bsram_data_q;
`ifdef ESP32_PORT_EN
  assign spi_ack     = spi_ack_q;
  assign spi_q       = spi_data_q;
`endif

endmodule

// File: tb/tb_main_ram_arbiter.sv
// tb_main_ram_arbiter
//   Directed bench for main_ram_arbiter with a small SDRAM controller model:
//   mem_busy rises the cycle after a strobe and stays high busy_len cycles
//   (busy_len = 0 means the model never goes busy).
`timescale 1ns/1ps
module tb_main_ram_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_done, load_req, load_ack;
  logic [24:0] load_addr;
  logic [15:0] load_data;
  logic        rom_req, rom_word, rom_valid;
  logic [23:0] rom_addr;
  logic [15:0] rom_q;
  logic        bsram_req, bsram_we, bsram_valid;
  logic [19:0] bsram_addr;
  logic [7:0]  bsram_d, bsram_q;
`ifdef ESP32_PORT_EN
  logic        spi_req, spi_we, spi_ack;
  logic [24:0] spi_addr;
  logic [7:0]  spi_d, spi_q;
`endif
  logic [24:0] mem_addr;
  logic        mem_rd, mem_wr, mem_word, mem_busy;
  logic [15:0] mem_din;
  logic [15:0] mem_dout = 16'h0000;

  int chk_cnt = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  main_ram_arbiter dut (
    .clk(clk), .reset_n(reset_n), .load_done(load_done),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data), .load_ack(load_ack),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_word(rom_word), .rom_q(rom_q), .rom_valid(rom_valid),
    .bsram_req(bsram_req), .bsram_we(bsram_we), .bsram_addr(bsram_addr), .bsram_d(bsram_d),
    .bsram_q(bsram_q), .bsram_valid(bsram_valid),
`ifdef ESP32_PORT_EN
    .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_d(spi_d),
    .spi_q(spi_q), .spi_ack(spi_ack),
`endif
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_word(mem_word),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_busy(mem_busy)
  );

  // SDRAM model
  int          busy_len = 1;
  int          busy_cnt = 0;
  int          strobe_cnt = 0;
  logic [24:0] last_addr = '0;
  logic [15:0] last_din = '0;
  logic        last_word = 1'b0;
  logic        last_wr = 1'b0;
  logic [15:0] mem_arr [32];
  logic        mem_vld [32] = '{default: 1'b0};

  assign mem_busy = (busy_cnt != 0);

  function automatic logic [4:0] midx(input logic [24:0] a);
    return {a[24], a[3:0]};
  endfunction

  always @(posedge clk) begin
    if (mem_rd || mem_wr) begin
      busy_cnt   <= busy_len;
      strobe_cnt <= strobe_cnt + 1;
      last_addr  <= mem_addr;
      last_din   <= mem_din;
      last_word  <= mem_word;
      last_wr    <= mem_wr;
      if (mem_wr) begin
        mem_arr[midx(mem_addr)] <= mem_din;
        mem_vld[midx(mem_addr)] <= 1'b1;
      end else if (mem_vld[midx(mem_addr)]) begin
        mem_dout <= mem_arr[midx(mem_addr)];
      end else begin
        mem_dout <= (mem_addr == 25'h0012345) ? 16'hA55A : 16'h0000;
      end
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int who, input logic v);
    case (who)
      0: load_req = v;
      1: rom_req = v;
      2: bsram_req = v;
`ifdef ESP32_PORT_EN
      3: spi_req = v;
`endif
      default: ;
    endcase
  endtask

  function automatic logic pulse(input int who);
    case (who)
      0: return load_ack;
      1: return rom_valid;
      2: return bsram_valid;
`ifdef ESP32_PORT_EN
      3: return spi_ack;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Raise a request in the current cycle and drop it in the cycle its pulse
  // is seen; returns the cycle count from request to pulse, -1 on timeout.
  task automatic run_req(input int who, output int cyc);
    cyc = -1;
    set_req(who, 1'b1);
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (pulse(who)) begin
        cyc = i;
        break;
      end
    end
    set_req(who, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    chk_cnt++; if ({mem_rd, mem_wr, mem_word} !== 3'b000) $display("FAIL reset_strobes: got %b expected 000", {mem_rd, mem_wr, mem_word}); else pass_cnt++;
    chk_cnt++; if (mem_addr !== 25'h0) $display("FAIL reset_addr: got %h expected 0", mem_addr); else pass_cnt++;
    chk_cnt++; if (mem_din !== 16'h0) $display("FAIL reset_din: got %h expected 0", mem_din); else pass_cnt++;
    chk_cnt++; if ({load_ack, rom_valid, bsram_valid} !== 3'b000) $display("FAIL reset_pulses: got %b expected 000", {load_ack, rom_valid, bsram_valid}); else pass_cnt++;
    chk_cnt++; if ({rom_q, bsram_q} !== 24'h0) $display("FAIL reset_data: got %h expected 0", {rom_q, bsram_q}); else pass_cnt++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_loader();
    int cyc, s0, seen;
    busy_len = 2; load_done = 1'b0;
    load_addr = 25'h000123; load_data = 16'hBEEF;
    rom_addr = 24'h012345; rom_word = 1'b1;
    rom_req = 1'b1;
    s0 = strobe_cnt;
    run_req(0, cyc);
    chk_cnt++; if (cyc !== 5) $display("FAIL load_latency: got %0d expected 5", cyc); else pass_cnt++;
    chk_cnt++; if ({last_wr, last_word} !== 2'b11) $display("FAIL load_cmd: got wr/word %b expected 11", {last_wr, last_word}); else pass_cnt++;
    chk_cnt++; if (last_addr !== 25'h000123) $display("FAIL load_addr: got %h expected 0000123", last_addr); else pass_cnt++;
    chk_cnt++; if (last_din !== 16'hBEEF) $display("FAIL load_din: got %h expected beef", last_din); else pass_cnt++;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rom_valid) seen++;
    end
    chk_cnt++; if (strobe_cnt - s0 !== 1 || seen !== 0) $display("FAIL load_rom_blocked: got strobes %0d rom pulses %0d expected 1 0", strobe_cnt - s0, seen); else pass_cnt++;
    rom_req = 1'b0;
    tick();
  endtask

  task automatic test_rom_read();
    int cyc;
    busy_len = 3; load_done = 1'b1;
    rom_addr = 24'h012345; rom_word = 1'b1;
    run_req(1, cyc);
    chk_cnt++; if (cyc !== 6) $display("FAIL rom_latency: got %0d expected 6", cyc); else pass_cnt++;
    chk_cnt++; if (last_addr !== 25'h0012345) $display("FAIL rom_addr: got %h expected 0012345", last_addr); else pass_cnt++;
    chk_cnt++; if ({last_wr, last_word} !== 2'b01) $display("FAIL rom_cmd: got wr/word %b expected 01", {last_wr, last_word}); else pass_cnt++;
    chk_cnt++; if (rom_q !== 16'hA55A) $display("FAIL rom_data: got %h expected a55a", rom_q); else pass_cnt++;
    tick();
    chk_cnt++; if (rom_valid !== 1'b0) $display("FAIL rom_pulse_width: got %b expected 0", rom_valid); else pass_cnt++;
  endtask

  task automatic test_bsram();
    int cyc;
    busy_len = 1;
    bsram_we = 1'b1; bsram_addr = 20'h00010; bsram_d = 8'h7E;
    run_req(2, cyc);
    chk_cnt++; if (cyc !== 4) $display("FAIL bsram_wr_latency: got %0d expected 4", cyc); else pass_cnt++;
    chk_cnt++; if (last_addr !== 25'h1000010) $display("FAIL bsram_addr: got %h expected 1000010", last_addr); else pass_cnt++;
    chk_cnt++; if (last_din !== 16'h7E7E) $display("FAIL bsram_din: got %h expected 7e7e", last_din); else pass_cnt++;
    chk_cnt++; if ({last_wr, last_word} !== 2'b10) $display("FAIL bsram_wr_cmd: got wr/word %b expected 10", {last_wr, last_word}); else pass_cnt++;
    bsram_we = 1'b0; bsram_d = 8'h00;
    run_req(2, cyc);
    chk_cnt++; if (cyc !== 4) $display("FAIL bsram_rd_latency: got %0d expected 4", cyc); else pass_cnt++;
    chk_cnt++; if (last_wr !== 1'b0) $display("FAIL bsram_rd_cmd: got wr %b expected 0", last_wr); else pass_cnt++;
    chk_cnt++; if (bsram_q !== 8'h7E) $display("FAIL bsram_rd_data: got %h expected 7e", bsram_q); else pass_cnt++;
  endtask

  task automatic test_contention();
    int s0, t_b, t_r;
    busy_len = 1; t_b = -1; t_r = -1;
    rom_addr = 24'h012345; rom_word = 1'b0;
    bsram_we = 1'b0; bsram_addr = 20'h00010;
    s0 = strobe_cnt;
    rom_req = 1'b1; bsram_req = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bsram_valid) begin bsram_req = 1'b0; t_b = i; end
      if (rom_valid)   begin rom_req = 1'b0;   t_r = i; end
      if (t_b >= 0 && t_r >= 0) break;
    end
    rom_req = 1'b0; bsram_req = 1'b0;
    tick(); tick(); tick(); tick();
    chk_cnt++; if (t_b !== 4) $display("FAIL cont_bsram_first: got cycle %0d expected 4", t_b); else pass_cnt++;
    chk_cnt++; if (t_r !== 8) $display("FAIL cont_rom_second: got cycle %0d expected 8", t_r); else pass_cnt++;
    chk_cnt++; if (strobe_cnt - s0 !== 2) $display("FAIL cont_strobes: got %0d expected 2", strobe_cnt - s0); else pass_cnt++;
  endtask

  task automatic test_no_busy();
    int cyc, s0;
    busy_len = 0;
    rom_addr = 24'h012345; rom_word = 1'b1;
    s0 = strobe_cnt;
    run_req(1, cyc);
    chk_cnt++; if (cyc !== 3) $display("FAIL nobusy_latency: got %0d expected 3", cyc); else pass_cnt++;
    chk_cnt++; if (strobe_cnt - s0 !== 1) $display("FAIL nobusy_strobes: got %0d expected 1", strobe_cnt - s0); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    busy_len = 5;
    rom_addr = 24'h012345; rom_word = 1'b1;
    rom_req = 1'b1;
    tick(); tick(); tick(); tick();
    reset_n = 1'b0;
    #1;
    chk_cnt++; if ({mem_rd, mem_wr, mem_word} !== 3'b000) $display("FAIL abort_strobes: got %b expected 000", {mem_rd, mem_wr, mem_word}); else pass_cnt++;
    chk_cnt++; if (mem_addr !== 25'h0) $display("FAIL abort_addr: got %h expected 0", mem_addr); else pass_cnt++;
    chk_cnt++; if (rom_q !== 16'h0) $display("FAIL abort_rom_q: got %h expected 0", rom_q); else pass_cnt++;
    rom_req = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rom_valid || load_ack || bsram_valid) seen++;
    end
    chk_cnt++; if (seen !== 0) $display("FAIL abort_no_pulse: got %0d pulses expected 0", seen); else pass_cnt++;
  endtask

`ifdef ESP32_PORT_EN
  task automatic test_starve();
    int roms, got;
    busy_len = 1; roms = 0; got = 0;
    rom_addr = 24'h012345; rom_word = 1'b1;
    spi_we = 1'b0; spi_addr = 25'h1000010; spi_d = 8'h00;
    rom_req = 1'b1; spi_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (spi_ack) begin got = 1; break; end
      if (rom_valid) roms++;
    end
    spi_req = 1'b0; rom_req = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk_cnt++; if (got !== 1) $display("FAIL spi_ack_seen: got %0d expected 1", got); else pass_cnt++;
    chk_cnt++; if (roms !== 8) $display("FAIL spi_ninth_grant: got %0d rom grants before spi expected 8", roms); else pass_cnt++;
    chk_cnt++; if (spi_q !== 8'h7E) $display("FAIL spi_data: got %h expected 7e", spi_q); else pass_cnt++;
  endtask
`endif

  initial begin
    load_done = 1'b0; load_req = 1'b0; load_addr = '0; load_data = '0;
    rom_req = 1'b0; rom_addr = '0; rom_word = 1'b0;
    bsram_req = 1'b0; bsram_we = 1'b0; bsram_addr = '0; bsram_d = '0;
`ifdef ESP32_PORT_EN
    spi_req = 1'b0; spi_we = 1'b0; spi_addr = '0; spi_d = '0;
`endif
    test_reset();
    test_loader();
    test_rom_read();
    test_bsram();
    test_contention();
    test_no_busy();
    test_reset_mid();
`ifdef ESP32_PORT_EN
    test_starve();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
